wb_mst_xbar: RTL and testbench

Parametrised Wishbone interconnect for the SoC peripheral bus: arbitrates N_MST bus masters (CPU data port, DMA, SPI-link bridge) onto N_SLV single-cycle-ack slaves with the existing flat `wb_cyc`/`wb_ack`/`wb_rdata` slave convention. Generalises the fixed single-master decode with round-robin arbitration, address-field slave select, decode-error and ack-timeout error responses, and an error counter. Sits between the masters' bus bridges and the peripheral slaves, clocked by the system clock.

---
 rtl/wb_mst_xbar.sv | 164 ++++++++++++++++
 tb/tb_wb_mst_xbar.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mst_xbar.sv
// wb_mst_xbar: round-robin N-master to N-slave Wishbone interconnect with
// address-field decode, decode-error/ack-timeout responses and an error counter.
module wb_mst_xbar #(
    parameter int N_MST     = 2,
    parameter int N_SLV     = 5,
    parameter int AW        = 22,
    parameter int DW        = 32,
    parameter int SEL_LSB   = 18,
    parameter int SEL_W     = 3,
    parameter int TO_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_MST*AW-1:0]   m_addr,
    input  logic [N_MST*DW-1:0]   m_wdata,
    input  logic [N_MST*DW/8-1:0] m_wmsk,
    input  logic [N_MST-1:0]      m_we,
    input  logic [N_MST-1:0]      m_cyc,
    output logic [N_MST-1:0]      m_ack,
    output logic [N_MST-1:0]      m_err,
    output logic [DW-1:0]         m_rdata,
    output logic [AW-1:0]         wb_addr,
    output logic [DW-1:0]         wb_wdata,
    output logic [DW/8-1:0]       wb_wmsk,
    output logic                  wb_we,
    output logic [N_SLV-1:0]      wb_cyc,
    input  logic [N_SLV-1:0]      wb_ack,
    input  logic [N_SLV*DW-1:0]   wb_rdata,
    output logic [7:0]            err_cnt,
    output logic                  busy
);
    localparam int MW = N_MST > 1 ? $clog2(N_MST) : 1;
    localparam int CW = TO_CYCLES > 0 ? $clog2(TO_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES > 0 ? TO_CYCLES - 1 : 0);
    localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [MW-1:0]    rr_q, rr_d, win_q, win_d, cand;
    logic [CW-1:0]    to_q, to_d;
    logic [AW-1:0]    wb_addr_q, wb_addr_d;
    logic [DW-1:0]    wb_wdata_q, wb_wdata_d, m_rdata_q, m_rdata_d, rsel;
    logic [DW/8-1:0]  wb_wmsk_q, wb_wmsk_d;
    logic             wb_we_q, wb_we_d, busy_q, busy_d, found, err_inc;
    logic [N_SLV-1:0] wb_cyc_q, wb_cyc_d;
    logic [N_MST-1:0] m_ack_q, m_ack_d, m_err_q, m_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [SEL_W-1:0] sel;

    always_comb begin
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_MST; k++)
            if (!found && m_cyc[(int'(rr_q) + k) % N_MST]) begin
                found = 1'b1;
                cand  = MW'((int'(rr_q) + k) % N_MST);
            end
        sel = m_addr[int'(cand)*AW + SEL_LSB +: SEL_W];
    end

    // wb_cyc_q is one-hot, so it doubles as the read-data mux select
    always_comb begin
        rsel = '0;
        for (int j = 0; j < N_SLV; j++)
            rsel = rsel | (wb_rdata[j*DW +: DW] & {DW{wb_cyc_q[j]}});
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        win_d      = win_q;
        to_d       = to_q;
        wb_addr_d  = wb_addr_q;
        wb_wdata_d = wb_wdata_q;
        wb_wmsk_d  = wb_wmsk_q;
        wb_we_d    = wb_we_q;
        wb_cyc_d   = wb_cyc_q;
        m_ack_d    = '0;
        m_err_d    = '0;
        m_rdata_d  = m_rdata_q;
        err_inc    = 1'b0;
        case (state_q)
            S_IDLE: if (found) begin
                win_d = cand;
                rr_d  = (cand == MW'(N_MST - 1)) ? '0 : cand + 1'b1;
                if (int'(sel) < N_SLV) begin
                    wb_addr_d  = m_addr[int'(cand)*AW +: AW];
                    wb_wdata_d = m_wdata[int'(cand)*DW +: DW];
                    wb_wmsk_d  = m_wmsk[int'(cand)*(DW/8) +: DW/8];
                    wb_we_d    = m_we[cand];
                    wb_cyc_d   = N_SLV'(1) << sel;
                    to_d       = '0;
                    state_d    = S_WAIT;
                end else begin
                    m_err_d   = N_MST'(1) << cand;
                    m_rdata_d = '0;
                    err_inc   = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_WAIT: if (|(wb_ack & wb_cyc_q)) begin
                wb_cyc_d  = '0;
                m_rdata_d = rsel;
                m_ack_d   = m_cyc[win_q] ? N_MST'(1) << win_q : '0;
                state_d   = S_RESP;
            end else if (TO_CYCLES != 0 && to_q == TO_LAST) begin
                wb_cyc_d  = '0;
                m_rdata_d = '0;
                m_err_d   = m_cyc[win_q] ? N_MST'(1) << win_q : '0;
                err_inc   = 1'b1;
                state_d   = S_RESP;
            end else begin
                to_d = to_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        err_cnt_d = err_cnt_q + 8'(err_inc && err_cnt_q != 8'hFF);
        busy_d    = state_d != S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr_q       <= '0;
            win_q      <= '0;
            to_q       <= '0;
            wb_addr_q  <= '0;
            wb_wdata_q <= '0;
            wb_wmsk_q  <= '0;
            wb_we_q    <= 1'b0;
            wb_cyc_q   <= '0;
            m_ack_q    <= '0;
            m_err_q    <= '0;
            m_rdata_q  <= '0;
            err_cnt_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            win_q      <= win_d;
            to_q       <= to_d;
            wb_addr_q  <= wb_addr_d;
            wb_wdata_q <= wb_wdata_d;
            wb_wmsk_q  <= wb_wmsk_d;
            wb_we_q    <= wb_we_d;
            wb_cyc_q   <= wb_cyc_d;
            m_ack_q    <= m_ack_d;
            m_err_q    <= m_err_d;
            m_rdata_q  <= m_rdata_d;
            err_cnt_q  <= err_cnt_d;
            busy_q     <= busy_d;
        end
    end

    assign m_ack    = m_ack_q;
    assign m_err    = m_err_q;
    assign m_rdata  = m_rdata_q;
    assign wb_addr  = wb_addr_q;
    assign wb_wdata = wb_wdata_q;
    assign wb_wmsk  = wb_wmsk_q;
    assign wb_we    = wb_we_q;
    assign wb_cyc   = wb_cyc_q;
    assign err_cnt  = err_cnt_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_wb_mst_xbar.sv
// tb_wb_mst_xbar: directed and randomized checks of wb_mst_xbar against a
// transaction-level model of arbitration, decode, timeout and error counting.
module tb_wb_mst_xbar;
    localparam int N_MST = 2, N_SLV = 5, AW = 22, DW = 32, SEL_LSB = 18, SEL_W = 3, TO = 4;

    logic                  clk = 1'b0, rst_n = 1'b0;
    logic [N_MST*AW-1:0]   m_addr = '0;
    logic [N_MST*DW-1:0]   m_wdata = '0;
    logic [N_MST*DW/8-1:0] m_wmsk = '0;
    logic [N_MST-1:0]      m_we = '0, m_cyc = '0, m_ack, m_err;
    logic [DW-1:0]         m_rdata, wb_wdata;
    logic [AW-1:0]         wb_addr;
    logic [DW/8-1:0]       wb_wmsk;
    logic                  wb_we, busy;
    logic [N_SLV-1:0]      wb_cyc, wb_ack;
    logic [N_SLV*DW-1:0]   wb_rdata;
    logic [7:0]            err_cnt;

    int checks = 0, errors = 0;
    int model_err = 0, model_rr = 0;
    int wait_k [N_SLV];
    int age [N_SLV];
    logic [DW-1:0] rd_base [N_SLV];
    int wr_cnt = 0;
    logic [DW-1:0] last_wdata = '0;

    wb_mst_xbar #(.N_MST(N_MST), .N_SLV(N_SLV), .AW(AW), .DW(DW), .SEL_LSB(SEL_LSB),
                  .SEL_W(SEL_W), .TO_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmsk(m_wmsk),
        .m_we(m_we), .m_cyc(m_cyc), .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
        .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_wmsk(wb_wmsk), .wb_we(wb_we),
        .wb_cyc(wb_cyc), .wb_ack(wb_ack), .wb_rdata(wb_rdata), .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // slave models: ack after wait_k cycles of strobe, read data derived from address
    initial for (int j = 0; j < N_SLV; j++) begin
        age[j] = 0;
        wait_k[j] = 0;
    end
    always @(posedge clk)
        for (int j = 0; j < N_SLV; j++) begin
            age[j] <= wb_cyc[j] ? age[j] + 1 : 0;
            if (wb_cyc[j] && wb_ack[j] && wb_we) begin
                wr_cnt     <= wr_cnt + 1;
                last_wdata <= wb_wdata;
            end
        end
    always_comb begin
        wb_ack = '0;
        for (int j = 0; j < N_SLV; j++) wb_ack[j] = wb_cyc[j] && (age[j] == wait_k[j]);
    end
    for (genvar g = 0; g < N_SLV; g++) begin : g_slv
        assign wb_rdata[g*DW +: DW] = rd_base[g] ^ {14'b0, wb_addr[17:0]};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_txn(input int m, input logic [AW-1:0] addr, input logic we,
                          input logic [DW-1:0] wd, input logic [3:0] wm);
        int sel, k, exp_n, n, wr0;
        bit dec, tmo;
        logic [N_SLV-1:0] oh;
        logic [DW-1:0] exp_rd;
        sel    = int'(addr[SEL_LSB +: SEL_W]);
        dec    = sel >= N_SLV;
        k      = dec ? 0 : wait_k[sel];
        tmo    = !dec && k >= TO;
        exp_n  = dec ? 1 : tmo ? TO + 1 : 2 + k;
        oh     = dec ? '0 : N_SLV'(1 << sel);
        exp_rd = (dec || tmo) ? '0 : rd_base[sel] ^ {14'b0, addr[17:0]};
        if (dec || tmo) model_err = (model_err >= 255) ? 255 : model_err + 1;
        wr0 = wr_cnt;
        m_addr[m*AW +: AW]  = addr;
        m_we[m]             = we;
        m_wdata[m*DW +: DW] = wd;
        m_wmsk[m*4 +: 4]    = wm;
        m_cyc[m]            = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            chk("wb_cyc", 64'(wb_cyc), 64'((n < exp_n) ? oh : '0));
            if (n == 1 && !dec) begin
                chk("wb_addr", 64'(wb_addr), 64'(addr));
                chk("wb_we", 64'(wb_we), 64'(we));
                if (we) chk("wb_wdata", {28'h0, wb_wmsk, wb_wdata}, {28'h0, wm, wd});
            end
        end while (m_ack == '0 && m_err == '0 && n < 20);
        chk("resp_cycle", 64'(n), 64'(exp_n));
        chk("m_ack", 64'(m_ack), 64'((dec || tmo) ? 0 : 1 << m));
        chk("m_err", 64'(m_err), 64'((dec || tmo) ? 1 << m : 0));
        if (!dec) chk("m_rdata", 64'(m_rdata), 64'(exp_rd));
        chk("err_cnt", 64'(err_cnt), 64'(model_err));
        chk("busy_resp", 64'(busy), 64'd1);
        m_cyc[m] = 1'b0;
        model_rr = (m + 1) % N_MST;
        @(posedge clk); #1;
        chk("pulse_once", 64'({m_ack, m_err}), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
        if (!dec) chk("rdata_hold", 64'(m_rdata), 64'(exp_rd));
        chk("wr_cnt", 64'(wr_cnt - wr0), 64'((we && !dec && !tmo) ? 1 : 0));
        if (we && !dec && !tmo) chk("wr_data", 64'(last_wdata), 64'(wd));
    endtask

    initial begin
        int t, got;
        bit seen;
        logic [N_MST-1:0] pend;
        for (int j = 0; j < N_SLV; j++) rd_base[j] = $urandom;
        rd_base[2] = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {busy, err_cnt, wb_cyc, m_ack, m_err, wb_we}, '0);
        chk("rst_data", {wb_addr, m_rdata}, '0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // zero-wait read of slave 2
        wait_k[2] = 0;
        do_txn(0, AW'(2 << SEL_LSB), 1'b0, '0, '0);
        // decode error write from master 1
        do_txn(1, AW'(7 << SEL_LSB) | AW'(22'h123), 1'b1, 32'hCAFEF00D, 4'hF);
        // timeout, then ack in final timeout cycle
        wait_k[1] = 100;
        do_txn(0, AW'(1 << SEL_LSB) | AW'(22'h40), 1'b1, 32'h11112222, 4'h3);
        wait_k[1] = TO - 1;
        do_txn(1, AW'(1 << SEL_LSB) | AW'(22'h44), 1'b1, 32'h33334444, 4'hC);

        // both masters requesting continuously, one-wait slave
        wait_k[3] = 1;
        m_we = '0;
        m_addr = {AW'(3 << SEL_LSB) | AW'(22'h8), AW'(3 << SEL_LSB) | AW'(22'h4)};
        m_cyc = 2'b11;
        t = 0; got = 0; pend = '0;
        while (got < 8 && t < 100) begin
            @(posedge clk); #1;
            t++;
            m_cyc = m_cyc | pend;
            pend = '0;
            if ((m_ack | m_err) != '0) begin
                chk("rr_grant", 64'(m_ack), 64'(1 << model_rr));
                chk("rr_time", 64'(t), 64'(3 + 4 * got));
                model_rr = (model_rr + 1) % N_MST;
                m_cyc = m_cyc & ~m_ack;
                pend = m_ack;
                got++;
            end
        end
        chk("rr_count", 64'(got), 64'd8);
        m_cyc = '0;
        repeat (2) @(posedge clk);
        #1;

        // randomized single-master traffic
        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < N_SLV; j++) wait_k[j] = $urandom_range(0, 5);
            do_txn($urandom_range(0, 1), AW'($urandom), 1'($urandom), $urandom, 4'($urandom));
        end

        // master abandons its request while the slave is still waiting
        wait_k[4] = 2;
        t = wr_cnt;
        m_addr[0 +: AW] = AW'(4 << SEL_LSB);
        m_we[0] = 1'b1;
        m_wdata[0 +: DW] = 32'h0BADC0DE;
        m_cyc = 2'b01;
        @(posedge clk); #1;
        m_cyc = '0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if ((m_ack | m_err) != '0) seen = 1'b1;
        end
        chk("drop_no_resp", 64'(seen), 64'd0);
        chk("drop_wr_done", 64'(wr_cnt - t), 64'd1);
        chk("drop_idle", 64'(busy), 64'd0);
        model_rr = 1;

        // decode errors saturate the counter
        for (int i = 0; i < 300; i++)
            do_txn($urandom_range(0, 1), AW'($urandom_range(5, 7) << SEL_LSB), 1'b0, '0, '0);
        chk("err_sat", 64'(err_cnt), 64'd255);

        // asynchronous reset during WAIT, master 0 leaves rr_ptr at 1
        wait_k[0] = 100;
        m_addr[0 +: AW] = AW'(0);
        m_we = '0;
        m_cyc = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        chk("wait_cyc", 64'(wb_cyc), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outs", {busy, err_cnt, wb_cyc, m_ack, m_err}, '0);
        m_cyc = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        model_err = 0;
        @(posedge clk); #1;
        wait_k[1] = 0;
        m_addr = {AW'(1 << SEL_LSB), AW'(1 << SEL_LSB)};
        m_cyc = 2'b11;
        t = 0;
        while ((m_ack | m_err) == '0 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk("rst_grant", 64'(m_ack), 64'd1);
        chk("rst_time", 64'(t), 64'd2);
        m_cyc = '0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
